// File: rtl/md_audio_mixer.sv
// Time-multiplexed stereo mixer: snapshots NCH signed sources per sample tick,
// accumulates one gained channel per clock into L/R, then saturates and strobes out.
module md_audio_mixer #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned IW     = 16,
  parameter int unsigned GW     = 8,
  parameter int unsigned GSHIFT = 7,
  parameter int unsigned OW     = 16
) (
  input  logic                MCLK,
  input  logic                reset,
  input  logic                sample_tick,
  input  logic [NCH*IW-1:0]   ch_data,
  input  logic [NCH*GW-1:0]   ch_gain,
  input  logic [NCH-1:0]      ch_en,
  input  logic [2*NCH-1:0]    ch_pan,
  input  logic                clip_clear,
  output logic [OW-1:0]       out_l,
  output logic [OW-1:0]       out_r,
  output logic                out_valid,
  output logic                busy,
  output logic                clip_l,
  output logic                clip_r,
  output logic                overrun
);

  localparam int unsigned PW   = IW + GW + 1;
  localparam int unsigned AW   = PW + $clog2(NCH) + 1;
  localparam int unsigned IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDXW-1:0]      LAST = IDXW'(NCH - 1);
  localparam logic signed [OW-1:0] OMAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic signed [OW-1:0] OMIN = {1'b1, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

  state_t                 state_q, state_d;
  logic [IDXW-1:0]        idx_q, idx_d;
  logic signed [AW-1:0]   acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [NCH*IW-1:0]      data_q, data_d;
  logic [NCH*GW-1:0]      gain_q, gain_d;
  logic [NCH-1:0]         en_q, en_d;
  logic [2*NCH-1:0]       pan_q, pan_d;
  logic [OW-1:0]          out_l_q, out_l_d, out_r_q, out_r_d;
  logic                   out_valid_q, out_valid_d, busy_q, busy_d;
  logic                   clip_l_q, clip_l_d, clip_r_q, clip_r_d;
  logic                   overrun_q, overrun_d;

  logic [IW-1:0]          cur_data;
  logic [GW-1:0]          cur_gain;
  logic                   cur_l, cur_r;
  logic signed [PW-1:0]   prod;
  logic signed [AW-1:0]   sh_l, sh_r;
  logic [OW:0]            sat_l, sat_r;

  // Returns {clipped, saturated value}.
  function automatic logic [OW:0] sat(input logic signed [AW-1:0] v);
    if (v > AW'(OMAX))      return {1'b1, OMAX};
    else if (v < AW'(OMIN)) return {1'b1, OMIN};
    else                    return {1'b0, v[OW-1:0]};
  endfunction

  // Select the snapshotted channel addressed by idx_q.
  always_comb begin
    cur_data = '0;
    cur_gain = '0;
    cur_l    = 1'b0;
    cur_r    = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (idx_q == IDXW'(i)) begin
        cur_data = data_q[i*IW +: IW];
        cur_gain = gain_q[i*GW +: GW];
        cur_l    = en_q[i] & pan_q[2*i];
        cur_r    = en_q[i] & pan_q[2*i+1];
      end
    end
  end

  assign prod  = PW'($signed(cur_data)) * PW'($signed({1'b0, cur_gain}));
  assign sh_l  = acc_l_q >>> GSHIFT;
  assign sh_r  = acc_r_q >>> GSHIFT;
  assign sat_l = sat(sh_l);
  assign sat_r = sat(sh_r);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_l_d     = acc_l_q;
    acc_r_d     = acc_r_q;
    data_d      = data_q;
    gain_d      = gain_q;
    en_d        = en_q;
    pan_d       = pan_q;
    out_l_d     = out_l_q;
    out_r_d     = out_r_q;
    out_valid_d = 1'b0;
    clip_l_d    = clip_l_q & ~clip_clear;
    clip_r_d    = clip_r_q & ~clip_clear;
    // A tick during a computation is dropped; the set beats a coincident clear.
    overrun_d   = (overrun_q & ~clip_clear) | (sample_tick & (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (sample_tick) begin
          data_d  = ch_data;
          gain_d  = ch_gain;
          en_d    = ch_en;
          pan_d   = ch_pan;
          acc_l_d = '0;
          acc_r_d = '0;
          idx_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (cur_l) acc_l_d = acc_l_q + AW'(prod);
        if (cur_r) acc_r_d = acc_r_q + AW'(prod);
        if (idx_q == LAST) state_d = OUT;
        else               idx_d   = idx_q + IDXW'(1);
      end
      OUT: begin
        out_l_d     = sat_l[OW-1:0];
        out_r_d     = sat_r[OW-1:0];
        clip_l_d    = clip_l_d | sat_l[OW];
        clip_r_d    = clip_r_d | sat_r[OW];
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      data_q      <= '0;
      gain_q      <= '0;
      en_q        <= '0;
      pan_q       <= '0;
      out_l_q     <= '0;
      out_r_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      clip_l_q    <= 1'b0;
      clip_r_q    <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_l_q     <= acc_l_d;
      acc_r_q     <= acc_r_d;
      data_q      <= data_d;
      gain_q      <= gain_d;
      en_q        <= en_d;
      pan_q       <= pan_d;
      out_l_q     <= out_l_d;
      out_r_q     <= out_r_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      clip_l_q    <= clip_l_d;
      clip_r_q    <= clip_r_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_l     = out_l_q;
  assign out_r     = out_r_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign clip_l    = clip_l_q;
  assign clip_r    = clip_r_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_md_audio_mixer.sv
// Bench for md_audio_mixer: directed and random vectors against an arithmetic
// mixing model, plus hand-timed overrun, clip-clear and reset sequences.
module tb_md_audio_mixer;

  logic        MCLK = 1'b0;
  logic        reset, sample_tick, clip_clear;
  logic [63:0] ch_data;
  logic [31:0] ch_gain;
  logic [3:0]  ch_en;
  logic [7:0]  ch_pan;
  logic [15:0] out_l, out_r;
  logic        out_valid, busy, clip_l, clip_r, overrun;

  int total = 0;
  int bad   = 0;

  always #5 MCLK = ~MCLK;

  md_audio_mixer #(.NCH(4), .IW(16), .GW(8), .GSHIFT(7), .OW(16)) dut (
    .MCLK(MCLK), .reset(reset), .sample_tick(sample_tick),
    .ch_data(ch_data), .ch_gain(ch_gain), .ch_en(ch_en), .ch_pan(ch_pan),
    .clip_clear(clip_clear), .out_l(out_l), .out_r(out_r),
    .out_valid(out_valid), .busy(busy), .clip_l(clip_l), .clip_r(clip_r),
    .overrun(overrun)
  );

  typedef struct {
    logic [63:0] data;
    logic [31:0] gain;
    logic [3:0]  en;
    logic [7:0]  pan;
    int          el;
    int          er;
    bit          cl;
    bit          cr;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge MCLK);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input int d0, input int d1, input int d2, input int d3,
                               input logic [31:0] g, input logic [3:0] en,
                               input logic [7:0] pan, input int el, input int er,
                               input bit cl, input bit cr);
    vec_t v;
    v.data = {16'(d3), 16'(d2), 16'(d1), 16'(d0)};
    v.gain = g;
    v.en   = en;
    v.pan  = pan;
    v.el   = el;
    v.er   = er;
    v.cl   = cl;
    v.cr   = cr;
    return v;
  endfunction

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Mixing rule: sum gained sources per side, divide by 128 rounding down, clamp to 16 bits.
  function automatic vec_t model(input vec_t v);
    vec_t   r;
    longint sl, sr, p, ql, qr;
    r  = v;
    sl = 0;
    sr = 0;
    for (int i = 0; i < 4; i++) begin
      p = longint'($signed(v.data[i*16 +: 16])) * longint'(v.gain[i*8 +: 8]);
      if (v.en[i] && v.pan[2*i])   sl += p;
      if (v.en[i] && v.pan[2*i+1]) sr += p;
    end
    ql   = floor_div(sl, 128);
    qr   = floor_div(sr, 128);
    r.cl = (ql > 32767) || (ql < -32768);
    r.cr = (qr > 32767) || (qr < -32768);
    r.el = int'((ql > 32767) ? 32767 : (ql < -32768) ? -32768 : ql);
    r.er = int'((qr > 32767) ? 32767 : (qr < -32768) ? -32768 : qr);
    return r;
  endfunction

  task automatic run_vec(input vec_t v, input string tag, input bit clr);
    int lat;
    if (clr) begin
      clip_clear = 1'b1;
      step();
      clip_clear = 1'b0;
    end
    ch_data = v.data;
    ch_gain = v.gain;
    ch_en   = v.en;
    ch_pan  = v.pan;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chk({tag, ".busy"}, longint'(busy), 1);
    // Inputs changed after the snapshot must not affect this sample.
    ch_data = {$urandom(), $urandom()};
    ch_gain = ~v.gain;
    ch_en   = ~v.en;
    ch_pan  = ~v.pan;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, ".latency"}, lat, 6);
    chk({tag, ".out_l"}, longint'($signed(out_l)), v.el);
    chk({tag, ".out_r"}, longint'($signed(out_r)), v.er);
    chk({tag, ".clip_l"}, longint'(clip_l), longint'(v.cl));
    chk({tag, ".clip_r"}, longint'(clip_r), longint'(v.cr));
    step();
    chk({tag, ".strobe_len"}, longint'(out_valid), 0);
    chk({tag, ".hold_l"}, longint'($signed(out_l)), v.el);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   nvalid, vcyc;

    reset = 1'b1; sample_tick = 1'b0; clip_clear = 1'b0;
    ch_data = '0; ch_gain = '0; ch_en = '0; ch_pan = '0;
    step();
    step();
    chk("rst.out_l", longint'(out_l), 0);
    chk("rst.out_r", longint'(out_r), 0);
    chk("rst.out_valid", longint'(out_valid), 0);
    chk("rst.busy", longint'(busy), 0);
    chk("rst.clip_l", longint'(clip_l), 0);
    chk("rst.clip_r", longint'(clip_r), 0);
    chk("rst.overrun", longint'(overrun), 0);
    reset = 1'b0;
    step();

    vecs.push_back(mkv(1000, 0, 0, 0, 32'h0000_0080, 4'b0001, 8'b0000_0001, 1000, 0, 0, 0));
    vecs.push_back(mkv(1000, -300, 5000, 0, 32'h8080_8080, 4'b0011, 8'b0011_1101, 700, -300, 0, 0));
    vecs.push_back(mkv(32767, 32767, 32767, 32767, 32'hFFFF_FFFF, 4'hF, 8'hFF, 32767, 32767, 1, 1));
    vecs.push_back(mkv(-32768, -32768, -32768, -32768, 32'hFFFF_FFFF, 4'hF, 8'hFF, -32768, -32768, 1, 1));
    vecs.push_back(mkv(-1, 0, 0, 0, 32'h0000_0001, 4'b0001, 8'b0000_0001, -1, 0, 0, 0));
    vecs.push_back(mkv(1, 0, 0, 0, 32'h0000_0001, 4'b0001, 8'b0000_0001, 0, 0, 0, 0));
    vecs.push_back(mkv(32767, 0, 0, 0, 32'h0000_0080, 4'b0001, 8'b0000_0011, 32767, 32767, 0, 0));
    vecs.push_back(mkv(-32768, -1, 0, 0, 32'h0000_8080, 4'b0011, 8'b0000_0101, -32768, 0, 1, 0));
    vecs.push_back(mkv(12345, -5, 7, 9, 32'h0000_0000, 4'hF, 8'hFF, 0, 0, 0, 0));
    vecs.push_back(mkv(-200, 0, 0, 0, 32'h0000_0001, 4'b0001, 8'b0000_0010, 0, -2, 0, 0));
    for (int k = 0; k < 24; k++) begin
      v.data = {$urandom(), $urandom()};
      if (k % 4 == 0) v.data[15:0] = 16'h7FFF;
      if (k % 4 == 1) v.data[31:16] = 16'h8000;
      v.gain = $urandom();
      v.en   = 4'($urandom_range(0, 15));
      v.pan  = 8'($urandom_range(0, 255));
      vecs.push_back(model(v));
    end
    for (int k = 0; k < vecs.size(); k++) run_vec(vecs[k], $sformatf("vec%0d", k), 1'b1);

    // Sticky clip survives a clean sample; clear takes effect next edge.
    run_vec(vecs[2], "sticky_set", 1'b1);
    v = vecs[0];
    v.cl = 1'b1;
    v.cr = 1'b1;
    run_vec(v, "sticky_hold", 1'b0);
    clip_clear = 1'b1;
    step();
    clip_clear = 1'b0;
    chk("clear.clip_l", longint'(clip_l), 0);
    chk("clear.clip_r", longint'(clip_r), 0);

    // clip_clear landing on the saturating OUT cycle: set wins.
    ch_data = vecs[2].data; ch_gain = vecs[2].gain; ch_en = vecs[2].en; ch_pan = vecs[2].pan;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    for (int c = 0; c < 4; c++) step();
    clip_clear = 1'b1;
    step();
    clip_clear = 1'b0;
    chk("clrset.valid", longint'(out_valid), 1);
    chk("clrset.clip_l", longint'(clip_l), 1);
    chk("clrset.clip_r", longint'(clip_r), 1);
    clip_clear = 1'b1;
    step();
    clip_clear = 1'b0;

    // Second tick at T+2 is dropped and flags overrun.
    chk("ovr.pre", longint'(overrun), 0);
    ch_data = vecs[0].data; ch_gain = vecs[0].gain; ch_en = vecs[0].en; ch_pan = vecs[0].pan;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chk("ovr.flag", longint'(overrun), 1);
    nvalid = 0;
    vcyc   = 0;
    for (int c = 4; c <= 12; c++) begin
      step();
      if (out_valid) begin
        nvalid++;
        vcyc = c;
      end
    end
    chk("ovr.nvalid", nvalid, 1);
    chk("ovr.vcycle", vcyc, 6);
    chk("ovr.out_l", longint'($signed(out_l)), 1000);
    clip_clear = 1'b1;
    step();
    clip_clear = 1'b0;
    chk("ovr.cleared", longint'(overrun), 0);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    sample_tick = 1'b1;
    clip_clear  = 1'b1;
    step();
    sample_tick = 1'b0;
    clip_clear  = 1'b0;
    chk("ovr.setwins", longint'(overrun), 1);
    for (int c = 0; c < 8; c++) step();

    // Reset at T+3 discards the in-flight sample.
    run_vec(vecs[2], "pre_rst", 1'b1);
    ch_data = vecs[0].data; ch_gain = vecs[0].gain; ch_en = vecs[0].en; ch_pan = vecs[0].pan;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst.out_l", longint'(out_l), 0);
    chk("mrst.out_r", longint'(out_r), 0);
    chk("mrst.busy", longint'(busy), 0);
    chk("mrst.clip_l", longint'(clip_l), 0);
    chk("mrst.clip_r", longint'(clip_r), 0);
    chk("mrst.overrun", longint'(overrun), 0);
    nvalid = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) nvalid++;
      step();
    end
    chk("mrst.novalid", nvalid, 0);
    run_vec(vecs[1], "post_rst", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
